// File: rtl/debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
// The state encoding lets db and busy fall straight out of the state bits.
package debounce_pkg;

   localparam int DB_STABLE_CYCLES_DEFAULT = 1_000_000;
   localparam int DB_SYNC_STAGES_DEFAULT   = 2;

   typedef enum logic [1:0] {
      ZERO  = 2'b00,
      WAIT1 = 2'b01,
      ONE   = 2'b11,
      WAIT0 = 2'b10
   } db_state_t;

   function automatic logic state_db(input db_state_t st);
      logic r;
      r = 1'b0;
      unique case (st)
         ONE, WAIT0:  r = 1'b1;
         ZERO, WAIT1: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic state_busy(input db_state_t st);
      logic r;
      r = 1'b0;
      unique case (st)
         WAIT1, WAIT0: r = 1'b1;
         ZERO, ONE:    r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/debounce_if.sv
// Raw button in, debounced level and qualification flag out.
// master drives the button; slave is the debouncer.
interface debounce_if;

   logic btn_in;
   logic db;
   logic busy;

   modport master (
      output btn_in,
      input  db,
      input  busy
   );

   modport slave (
      input  btn_in,
      output db,
      output busy
   );

endinterface

// File: rtl/debounce_sync_ff.sv
// N-stage metastability synchronizer, async active-low reset to 0.
// Reused for the UART rx line.
module sync_ff #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [N-1:0] r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r <= '0;
      end else begin
         r <= {r[N-2:0], d};
      end
   end

   assign q = r[N-1];

endmodule

// File: rtl/debounce.sv
// Debouncer: synchronizer, 4-state qualify FSM and stability down-counter.
// db/busy decode from the state register only, so they never glitch.
module debounce
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DB_STABLE_CYCLES_DEFAULT,
   parameter int SYNC_STAGES   = DB_SYNC_STAGES_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   debounce_if.slave  bus
);

   localparam int CW = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] LOAD = CW'(STABLE_CYCLES - 1);

   logic          s;
   db_state_t     state;
   db_state_t     state_nx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic          cnt_zero;

   sync_ff #(
      .N(SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (bus.btn_in),
      .q    (s)
   );

   assign cnt_zero = (cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ZERO;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // A bounce during WAIT drops back to the old level; the count restarts fresh.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         ZERO: begin
            if (s) begin
               state_nx = WAIT1;
               cnt_nx   = LOAD;
            end
         end
         WAIT1: begin
            if (!s) begin
               state_nx = ZERO;
               cnt_nx   = '0;
            end else if (cnt_zero) begin
               state_nx = ONE;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         ONE: begin
            if (!s) begin
               state_nx = WAIT0;
               cnt_nx   = LOAD;
            end
         end
         WAIT0: begin
            if (s) begin
               state_nx = ONE;
               cnt_nx   = '0;
            end else if (cnt_zero) begin
               state_nx = ZERO;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
      endcase
   end

   assign bus.db   = state_db(state);
   assign bus.busy = state_busy(state);

endmodule

// File: tb/tb_debounce.sv
// Directed bench for debounce with STABLE_CYCLES=8, SYNC_STAGES=2.
// Expected db/busy per cycle are queued up front and popped after each edge.
module tb_debounce;

   typedef struct packed {
      logic db;
      logic busy;
   } exp_t;

   logic  clk;
   logic  rst_n;
   exp_t  sb[$];
   string tag;
   int    nvec;
   int    nfail;
   int    cyc;

   debounce_if dif ();

   debounce #(
      .STABLE_CYCLES(8),
      .SYNC_STAGES  (2)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic seg(input int n, input logic d, input logic b);
      exp_t e;
      e.db   = d;
      e.busy = b;
      for (int i = 0; i < n; i++) sb.push_back(e);
   endtask

   task automatic check_now();
      exp_t e;
      nvec++;
      assert (sb.size() != 0) else begin
         nfail++;
         $error("FAIL %s queue: observed empty, expected entry (cyc %0d)",
                tag, cyc);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         nvec++;
         assert (dif.db === e.db) else begin
            nfail++;
            $error("FAIL %s db: observed %b expected %b (cyc %0d)",
                   tag, dif.db, e.db, cyc);
         end
         nvec++;
         assert (dif.busy === e.busy) else begin
            nfail++;
            $error("FAIL %s busy: observed %b expected %b (cyc %0d)",
                   tag, dif.busy, e.busy, cyc);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      check_now();
   endtask

   task automatic drive(input logic b, input int n);
      dif.btn_in = b;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic done();
      nvec++;
      assert (sb.size() == 0) else begin
         nfail++;
         $error("FAIL %s leftover: observed %0d expected 0", tag, sb.size());
      end
      sb.delete();
   endtask

   initial begin
      nvec       = 0;
      nfail      = 0;
      cyc        = 0;
      rst_n      = 1'b0;
      dif.btn_in = 1'b0;

      tag = "reset";
      #3;
      seg(1, 0, 0);
      check_now();
      seg(2, 0, 0);
      drive(0, 2);
      #3 rst_n = 1'b1;
      seg(5, 0, 0);
      drive(0, 5);
      done();

      tag = "press";
      seg(2, 0, 0); seg(8, 0, 1); seg(20, 1, 0);
      drive(1, 30);
      done();

      tag = "release";
      seg(2, 1, 0); seg(8, 1, 1); seg(10, 0, 0);
      drive(0, 20);
      done();

      tag = "bouncy";
      seg(2, 0, 0); seg(3, 0, 1);
      seg(2, 0, 0); seg(5, 0, 1);
      seg(2, 0, 0); seg(7, 0, 1);
      seg(2, 0, 0); seg(8, 0, 1);
      seg(20, 1, 0);
      drive(1, 3); drive(0, 2);
      drive(1, 5); drive(0, 2);
      drive(1, 7); drive(0, 2);
      drive(1, 30);
      done();

      tag = "glitch";
      seg(2, 1, 0); seg(8, 1, 1); seg(18, 1, 0);
      drive(0, 8);
      drive(1, 20);
      done();

      tag = "release2";
      seg(2, 1, 0); seg(8, 1, 1); seg(10, 0, 0);
      drive(0, 20);
      done();

      tag = "width8";
      seg(2, 0, 0); seg(8, 0, 1); seg(18, 0, 0);
      drive(1, 8);
      drive(0, 20);
      done();

      tag = "width9";
      seg(2, 0, 0); seg(8, 0, 1); seg(1, 1, 0);
      seg(8, 1, 1); seg(20, 0, 0);
      drive(1, 9);
      drive(0, 30);
      done();

      tag = "rst_mid";
      seg(2, 0, 0); seg(4, 0, 1);
      drive(1, 6);
      #2 rst_n = 1'b0;
      #1;
      seg(1, 0, 0);
      check_now();
      seg(2, 0, 0);
      drive(1, 2);
      #3 rst_n = 1'b1;
      seg(2, 0, 0); seg(8, 0, 1); seg(10, 1, 0);
      drive(1, 20);
      done();

      tag = "rst_rel";
      seg(2, 1, 0); seg(8, 1, 1); seg(10, 0, 0);
      drive(0, 20);
      done();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/debounce.md
# debounce

Debounces a raw, asynchronous mechanical input (push-button or switch) into a clean, synchronous level `db`. It sits directly upstream of the positive-edge detector: `db` connects straight to that stage's `db` input, which turns each debounced press into a single-cycle pulse for the UART control logic. Internally it has a synchronizer chain, a 4-state FSM and a stability down-counter.

## Interface
- `STABLE_CYCLES`, default 1_000_000 (10 ms at 100 MHz): number of consecutive clk cycles the synchronized input must hold a new level before `db` follows it; must be ≥ 2.
- `SYNC_STAGES`, default 2: flip-flops in the input synchronizer; must be ≥ 2.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `btn_in`  in  1  raw, unsynchronized, bouncing input.
- `db`  out  1  debounced level.
- `busy`  out  1  high while a candidate level change is being qualified (FSM in WAIT1 or WAIT0).

## Operation
- Synchronizer: `SYNC_STAGES`-deep shift register clocked by clk; its last stage is `s`. No other logic may read `btn_in`.
- Counter `cnt`, width $clog2(STABLE_CYCLES); loaded with STABLE_CYCLES-1 on entry to a WAIT state, decrements by 1 each cycle in WAIT, never wraps (never decremented at 0).
- FSM states and transitions (evaluated each rising edge):
  - ZERO: `s`=1 → WAIT1, load cnt; else stay.
  - WAIT1: `s`=0 → ZERO (candidate rejected, cnt discarded); `s`=1 and cnt=0 → ONE; else cnt−1.
  - ONE: `s`=0 → WAIT0, load cnt; else stay.
  - WAIT0: `s`=1 → ONE (rejected); `s`=0 and cnt=0 → ZERO; else cnt−1.
- Outputs decoded from the state register only (glitch-free, no combinational path from `btn_in`): `db`=1 in ONE or WAIT0; `busy`=1 in WAIT1 or WAIT0.
- Any bounce during WAIT returns the FSM to the previous stable state. The next change restarts the full count, with no partial credit.
- Reset (`rst_n`=0, any time including mid-WAIT): synchronizer all 0, state ZERO, cnt 0, `db`=0, `busy`=0, effective immediately without a clock.
- `btn_in` held high through reset release: treated as a new press, so `db` rises only after full qualification.

## Timing
- Edge numbering: edge 0 is the first rising edge that samples a new, subsequently stable `btn_in` level.
- `s` reflects it after edge SYNC_STAGES−1. The FSM enters WAIT at edge SYNC_STAGES (`busy` rises).
- `db` changes, and `busy` falls, immediately after edge SYNC_STAGES+STABLE_CYCLES. Latency is identical for press and release.
- Rejection: if `s` reverts while in WAIT, `busy` falls after that same edge and `db` is unchanged.
- Minimum accepted pulse width at `btn_in`: STABLE_CYCLES+1 cycles. Any shorter pulse never reaches `db`.

## Structure
- Shared package `debounce_pkg`: state enum {ZERO, WAIT1, ONE, WAIT0} (2-bit encoding) and default constants (DB_STABLE_CYCLES_DEFAULT, DB_SYNC_STAGES_DEFAULT).
- One sub-module, `sync_ff`: parameterized N-stage synchronizer with async active-low reset to 0. It is reusable for the UART rx line.
- The FSM and counter live in `debounce` itself.

## Test plan
Run with STABLE_CYCLES=8, SYNC_STAGES=2.
- Clean press: `btn_in` 0→1 at edge 0, held 30 cycles → `busy`=1 after edges 2..9, `db`=1 after edge 10 and stays 1. Downstream edge detector emits exactly one 1-cycle `ped` pulse.
- Bouncy press: `btn_in` toggles with high pulses of 3, 5, 7 cycles separated by 2-cycle lows, then held high → `db` rises exactly 10 edges after the final 0→1, with no earlier `db` activity. `busy` pulses for each bounce.
- Release: with `db`=1, `btn_in` 1→0 at edge 0 → `db`=0 after edge 10. Also apply a 1→0→1 glitch of 8 cycles → `db` stays 1 and the FSM returns to ONE.
- Reset mid-qualification: assert `rst_n`=0 asynchronously at edge 5 of a press → `db`=0 and `busy`=0 immediately. After release with `btn_in` still high, `db` rises 10 edges after the first post-reset edge.
- Boundary width: high pulse of exactly 8 cycles → `db` stays 0. High pulse of exactly 9 cycles → `db` goes high for one qualification, then follows the release 10 edges later.
